// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard and the decoder.
package hazard_pkg;

    // rd field sized for the 32-entry RV32I register file.
    localparam int unsigned SB_RD_W = 5;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int unsigned FWD_RF = 0;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one source operand against the shadow pipeline; the youngest (lowest index)
// matching entry wins.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned IDX_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                       used,
    input  logic [REG_ADDR_W-1:0]      idx,
    input  sb_entry_t [NUM_STAGES-1:0] entries,
    output logic                       hit,
    output logic [IDX_W-1:0]           hit_idx,
    output logic                       hit_load
);

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_load = 1'b0;
        if (used && (idx != '0)) begin
            // Walk oldest to youngest so the youngest match overwrites.
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (entries[k].valid && (entries[k].rd == SB_RD_W'(idx))) begin
                    hit      = 1'b1;
                    hit_idx  = IDX_W'(k);
                    hit_load = entries[k].is_load;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller tracking in-flight destination tags (EX..WB).
// Define FORWARDING_EN to enable bypass selects; otherwise every RAW match stalls.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = 3,
    parameter int unsigned REG_ADDR_W    = 5,
    parameter int unsigned LOAD_LAT      = 2,
    parameter int unsigned STALL_TIMEOUT = 16,
    localparam int unsigned FWD_W        = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic                  id_rs1_used_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwen_i,
    input  logic                  id_is_load_i,
    input  logic                  pc_taken_i,
    input  logic                  mem_busy_i,
    output logic                  stall_if_o,
    output logic                  stall_id_o,
    output logic                  flush_id_o,
    output logic                  flush_ex_o,
    output logic                  freeze_o,
    output logic [FWD_W-1:0]      fwd_rs1_o,
    output logic [FWD_W-1:0]      fwd_rs2_o,
    output logic                  hazard_timeout_o
);

    localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);

    sb_entry_t [NUM_STAGES-1:0] shadow_q;
    sb_entry_t                  id_tag;

    logic             hit1, hit2, ld1, ld2;
    logic [FWD_W-1:0] idx1, idx2;
    logic             load_use1, load_use2;
    logic             haz1, haz2, hazard, hazard_stall;

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q;

    hazard_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_ADDR_W (REG_ADDR_W),
        .IDX_W      (FWD_W)
    ) u_match_rs1 (
        .used     (id_rs1_used_i),
        .idx      (id_rs1_i),
        .entries  (shadow_q),
        .hit      (hit1),
        .hit_idx  (idx1),
        .hit_load (ld1)
    );

    hazard_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_ADDR_W (REG_ADDR_W),
        .IDX_W      (FWD_W)
    ) u_match_rs2 (
        .used     (id_rs2_used_i),
        .idx      (id_rs2_i),
        .entries  (shadow_q),
        .hit      (hit2),
        .hit_idx  (idx2),
        .hit_load (ld2)
    );

    // Load data is unavailable until the producer reaches entry LOAD_LAT.
    assign load_use1 = hit1 & ld1 & (32'(idx1) < LOAD_LAT);
    assign load_use2 = hit2 & ld2 & (32'(idx2) < LOAD_LAT);

`ifdef FORWARDING_EN
    assign haz1      = load_use1;
    assign haz2      = load_use2;
    assign fwd_rs1_o = (hit1 && !haz1) ? idx1 + FWD_W'(1) : FWD_W'(FWD_RF);
    assign fwd_rs2_o = (hit2 && !haz2) ? idx2 + FWD_W'(1) : FWD_W'(FWD_RF);
`else
    logic unused_fwd;
    assign unused_fwd = ^{load_use1, load_use2, idx1, idx2};
    assign haz1       = hit1;
    assign haz2       = hit2;
    assign fwd_rs1_o  = FWD_W'(FWD_RF);
    assign fwd_rs2_o  = FWD_W'(FWD_RF);
`endif

    assign hazard       = haz1 | haz2;
    assign hazard_stall = hazard & ~pc_taken_i & ~mem_busy_i;
    assign freeze_o     = mem_busy_i;

    always_comb begin
        stall_if_o = 1'b0;
        stall_id_o = 1'b0;
        flush_id_o = 1'b0;
        flush_ex_o = 1'b0;
        if (mem_busy_i) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
        end else if (pc_taken_i) begin
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
        end else if (hazard) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            flush_ex_o = 1'b1;
        end
    end

    always_comb begin
        id_tag.valid   = id_regwen_i & (id_rd_i != '0);
        id_tag.rd      = SB_RD_W'(id_rd_i);
        id_tag.is_load = id_is_load_i;
    end

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (!mem_busy_i) begin
            if (!hazard_stall) begin
                wd_cnt_d = '0;
            end else if (wd_cnt_q != CNT_W'(STALL_TIMEOUT)) begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q  <= '0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!mem_busy_i) begin
                for (int k = NUM_STAGES - 1; k > 0; k--) begin
                    shadow_q[k] <= shadow_q[k-1];
                end
                shadow_q[0] <= (flush_ex_o || !id_valid_i) ? '0 : id_tag;
            end
            wd_cnt_q <= wd_cnt_d;
            if (wd_cnt_d == CNT_W'(STALL_TIMEOUT)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign hazard_timeout_o = timeout_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard; expected outputs are queued at drive time and
// checked on the falling edge. Expectation columns cover both FORWARDING_EN settings.
module tb_hazard_scoreboard;

    localparam int unsigned NS    = 3;
    localparam int unsigned RW    = 5;
    localparam int unsigned FW    = $clog2(NS + 1);
    // Short watchdog so a natural three-cycle RAW stall is enough to trip it.
    localparam int unsigned TMO_N = 2;

    // Expected-vector bits: {timeout, stall_if, stall_id, flush_id, flush_ex, freeze, fwd1, fwd2}
    localparam logic [9:0] S  = 10'h1A0;
    localparam logic [9:0] FL = 10'h060;
    localparam logic [9:0] FZ = 10'h190;
    localparam logic [9:0] T  = 10'h200;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
        logic       tk;
        logic       bz;
        logic [9:0] e_off;
        logic [9:0] e_on;
    } vec_t;

    typedef struct packed {
        int         id;
        logic [9:0] exp;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, rs1_used, rs2_used, regwen, is_load, pc_taken, mem_busy;
    logic [RW-1:0] rs1, rs2, rd;
    logic          stall_if, stall_id, flush_id, flush_ex, freeze, tmo;
    logic [FW-1:0] fwd1, fwd2;

    vec_t tbl[$];
    sb_t  exp_q[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_STAGES    (NS),
        .REG_ADDR_W    (RW),
        .LOAD_LAT      (2),
        .STALL_TIMEOUT (TMO_N)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .id_valid_i       (id_valid),
        .id_rs1_i         (rs1),
        .id_rs1_used_i    (rs1_used),
        .id_rs2_i         (rs2),
        .id_rs2_used_i    (rs2_used),
        .id_rd_i          (rd),
        .id_regwen_i      (regwen),
        .id_is_load_i     (is_load),
        .pc_taken_i       (pc_taken),
        .mem_busy_i       (mem_busy),
        .stall_if_o       (stall_if),
        .stall_id_o       (stall_id),
        .flush_id_o       (flush_id),
        .flush_ex_o       (flush_ex),
        .freeze_o         (freeze),
        .fwd_rs1_o        (fwd1),
        .fwd_rs2_o        (fwd2),
        .hazard_timeout_o (tmo)
    );

    function automatic vec_t v(input logic rst, input logic vld, input logic [4:0] r1,
                               input logic u1, input logic [4:0] r2, input logic u2,
                               input logic [4:0] d, input logic wen, input logic ld,
                               input logic tk, input logic bz, input logic [9:0] e_off,
                               input logic [9:0] e_on);
        vec_t r;
        r.rst = rst; r.vld = vld; r.rs1 = r1; r.u1 = u1; r.rs2 = r2; r.u2 = u2;
        r.rd = d; r.wen = wen; r.ld = ld; r.tk = tk; r.bz = bz;
        r.e_off = e_off; r.e_on = e_on;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        id_valid = r.vld; rs1 = r.rs1; rs1_used = r.u1; rs2 = r.rs2; rs2_used = r.u2;
        rd = r.rd; regwen = r.wen; is_load = r.ld; pc_taken = r.tk; mem_busy = r.bz;
    endtask

    // Called just after a rising edge; the row's outputs are checked on the next falling edge.
    task automatic apply(input vec_t r, input int id);
        sb_t e;
        if (r.rst) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
        end
        drive(r);
        e.id = id;
`ifdef FORWARDING_EN
        e.exp = r.e_on;
`else
        e.exp = r.e_off;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        sb_t        e;
        logic [9:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {tmo, stall_if, stall_id, flush_id, flush_ex, freeze, fwd1, fwd2};
            checks++;
            if (act === e.exp) passes++;
            else $display("FAIL row%0d outputs: got %b expected %b", e.id, act, e.exp);
        end
    end

    initial begin
        vec_t hv;
        rst_n = 1'b0;
        drive('0);

        // rst vld rs1 u1 rs2 u2 rd wen ld tk bz | no-forwarding | forwarding
        // ALU producer x5 followed by consumers of x5, then youngest-wins on x7.
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 5, 1, 0, 0, 7, 1, 0, 0, 0, S, 10'h004));
        tbl.push_back(v(0, 1, 5, 1, 0, 0, 7, 1, 0, 0, 0, S, 10'h008));
        tbl.push_back(v(0, 1, 5, 1, 0, 0, 7, 1, 0, 0, 0, S | T, 10'h00C));
        tbl.push_back(v(0, 1, 5, 1, 0, 0, 7, 1, 0, 0, 0, T, 0));
        tbl.push_back(v(0, 1, 7, 1, 7, 1, 0, 0, 0, 0, 0, S | T, 10'h005));
        // Load x6 then consumer on rs2.
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 1, 6, 1, 8, 1, 0, 0, 0, S, S));
        tbl.push_back(v(0, 1, 1, 1, 6, 1, 8, 1, 0, 0, 0, S, S));
        tbl.push_back(v(0, 1, 1, 1, 6, 1, 8, 1, 0, 0, 0, S | T, T | 10'h003));
        tbl.push_back(v(0, 1, 1, 1, 6, 1, 8, 1, 0, 0, 0, T, T));
        // x0 writes, non-writing producers, unused operands.
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 10, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0));
        // Taken branch during a load-use hazard squashes the ID instruction (x8).
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 6, 1, 8, 1, 0, 1, 0, FL, FL));
        tbl.push_back(v(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, S, 10'h003));
        // Memory wait in the middle of a load-use stall, with a taken branch while frozen.
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 6, 1, 0, 0, 8, 1, 0, 0, 0, S, S));
        tbl.push_back(v(0, 1, 6, 1, 0, 0, 8, 1, 0, 0, 1, FZ, FZ));
        tbl.push_back(v(0, 1, 6, 1, 0, 0, 8, 1, 0, 0, 1, FZ, FZ));
        tbl.push_back(v(0, 1, 6, 1, 0, 0, 8, 1, 0, 1, 1, FZ, FZ));
        tbl.push_back(v(0, 1, 6, 1, 0, 0, 8, 1, 0, 0, 1, FZ, FZ));
        tbl.push_back(v(0, 1, 6, 1, 0, 0, 8, 1, 0, 0, 1, FZ, FZ));
        tbl.push_back(v(0, 1, 6, 1, 0, 0, 8, 1, 0, 0, 0, S, S));
        tbl.push_back(v(0, 1, 6, 1, 0, 0, 8, 1, 0, 0, 0, S | T, T | 10'h00C));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0, T, T));
        // Mid-run reset clears shadow and watchdog flag; invalid ID leaves a bubble.
        tbl.push_back(v(1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Producer presented while reset is held across a clock edge must not be captured.
        rst_n = 1'b0;
        drive(v(0, 1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hv = v(0, 1, 13, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0);
        apply(hv, 100);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
